// File: rtl/mod_counter.sv
// Modulo-(MAX_VAL+1) up/down counter with clear, clamped load, enable and registered wrap strobes; 1-cycle latency.
// Define MOD_COUNTER_SATURATE_EN to saturate at the range ends and pulse wrap_up/wrap_dn on each blocked step instead.
module mod_counter #(
    parameter int          WIDTH   = 8,
    parameter int unsigned MAX_VAL = (2**WIDTH) - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap_up,
    output logic             wrap_dn
);

    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_up_q, wrap_up_d;
    logic             wrap_dn_q, wrap_dn_d;
    logic [WIDTH:0]   inc_ext, dec_ext;
    logic [WIDTH-1:0] load_clamped;

    // Extra headroom bit keeps the clamp compare exact when MAX_VAL is not 2**WIDTH-1.
    assign inc_ext      = {1'b0, count_q} + 1'b1;
    assign dec_ext      = {1'b0, count_q} - 1'b1;
    assign load_clamped = ({1'b0, load_val} > MAX_EXT) ? MAX_CNT : load_val;

    always_comb begin
        count_d   = count_q;
        wrap_up_d = 1'b0;
        wrap_dn_d = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_clamped;
        end else if (en) begin
            if (up) begin
                if (count_q == MAX_CNT) begin
`ifdef MOD_COUNTER_SATURATE_EN
                    count_d   = count_q;
`else
                    count_d   = '0;
`endif
                    wrap_up_d = 1'b1;
                end else begin
                    count_d = WIDTH'(inc_ext);
                end
            end else begin
                if (count_q == '0) begin
`ifdef MOD_COUNTER_SATURATE_EN
                    count_d   = count_q;
`else
                    count_d   = MAX_CNT;
`endif
                    wrap_dn_d = 1'b1;
                end else begin
                    count_d = WIDTH'(dec_ext);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            wrap_up_q <= 1'b0;
            wrap_dn_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrap_up_q <= wrap_up_d;
            wrap_dn_q <= wrap_dn_d;
        end
    end

    assign count   = count_q;
    assign wrap_up = wrap_up_q;
    assign wrap_dn = wrap_dn_q;
    assign at_max  = (count_q == MAX_CNT);
    assign at_min  = (count_q == '0);

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: MAX_VAL=9 main instance plus a MAX_VAL=255 instance.
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       rst, clr, load, en, up;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       at_max, at_min, wrap_up, wrap_dn;

    logic       p_clr, p_load, p_en, p_up;
    logic [7:0] p_load_val;
    logic [7:0] p_count;
    logic       p_at_max, p_at_min, p_wrap_up, p_wrap_dn;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(8), .MAX_VAL(9)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .count(count), .at_max(at_max), .at_min(at_min),
        .wrap_up(wrap_up), .wrap_dn(wrap_dn)
    );

    mod_counter #(.WIDTH(8), .MAX_VAL(255)) u_p2 (
        .clk(clk), .rst(rst), .clr(p_clr), .load(p_load), .load_val(p_load_val),
        .en(p_en), .up(p_up), .count(p_count), .at_max(p_at_max), .at_min(p_at_min),
        .wrap_up(p_wrap_up), .wrap_dn(p_wrap_dn)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_checks++;
        if ({count, wrap_up, wrap_dn, at_min, at_max} !== {8'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: count=%0d wu=%b wd=%b min=%b max=%b, need 0 0 0 1 0",
                     count, wrap_up, wrap_dn, at_min, at_max);
        end else n_pass++;
        n_checks++;
        if (p_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_p2: count=%0d need 0", p_count);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_up_count();
        int exp_c = 0;
        logic exp_w;
        en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            exp_w = (exp_c == 9);
`ifdef MOD_COUNTER_SATURATE_EN
            if (!exp_w) exp_c++;
`else
            exp_c = exp_w ? 0 : exp_c + 1;
`endif
            tick();
            n_checks++;
            if ({count, wrap_up, wrap_dn, at_max} !== {8'(exp_c), exp_w, 1'b0, (exp_c == 9)}) begin
                n_fail++;
                $display("FAIL up_count[%0d]: count=%0d wu=%b wd=%b max=%b, need %0d %b 0 %b",
                         i, count, wrap_up, wrap_dn, at_max, exp_c, exp_w, (exp_c == 9));
            end else n_pass++;
        end
        en = 1'b0;
    endtask

    task automatic test_down_wrap();
`ifdef MOD_COUNTER_SATURATE_EN
        logic [7:0] exp_c [4] = '{8'd1, 8'd0, 8'd0, 8'd0};
        logic       exp_w [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
        logic [7:0] exp_c [4] = '{8'd1, 8'd0, 8'd9, 8'd8};
        logic       exp_w [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
`endif
        load = 1'b1; load_val = 8'd2;
        tick();
        load = 1'b0;
        n_checks++;
        if ({count, wrap_up, wrap_dn} !== {8'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL down_load: count=%0d wu=%b wd=%b, need 2 0 0", count, wrap_up, wrap_dn);
        end else n_pass++;
        en = 1'b1; up = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({count, wrap_dn, wrap_up} !== {exp_c[i], exp_w[i], 1'b0}) begin
                n_fail++;
                $display("FAIL down_wrap[%0d]: count=%0d wd=%b wu=%b, need %0d %b 0",
                         i, count, wrap_dn, wrap_up, exp_c[i], exp_w[i]);
            end else n_pass++;
        end
        en = 1'b0;
    endtask

    task automatic test_priority_clamp();
        logic [7:0] exp_c [3] = '{8'd0, 8'd9, 8'd9};
        load = 1'b1; load_val = 8'd8;
        tick();
        clr = 1'b1; load = 1'b1; load_val = 8'd5; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({count, wrap_up, wrap_dn} !== {exp_c[i], 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL priority_clamp[%0d]: count=%0d wu=%b wd=%b, need %0d 0 0",
                         i, count, wrap_up, wrap_dn, exp_c[i]);
            end else n_pass++;
            clr = 1'b0; load_val = 8'd200;
        end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals  [3] = '{8'd3, 8'd7, 8'd12};
        logic [7:0] exp_c [3] = '{8'd3, 8'd7, 8'd9};
        load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            load_val = vals[i];
            tick();
            n_checks++;
            if (count !== exp_c[i]) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: count=%0d need %0d", i, count, exp_c[i]);
            end else n_pass++;
        end
        load = 1'b0;
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_val = 8'd6;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        n_checks++;
        if (count !== 8'd7) begin
            n_fail++;
            $display("FAIL async_pre: count=%0d need 7", count);
        end else n_pass++;
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({count, wrap_up} !== {8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_count: count=%0d wu=%b, need 0 0", count, wrap_up);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        // Pending wrap strobe cancelled by a mid-cycle reset.
        load = 1'b1; load_val = 8'd9; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        n_checks++;
        if (wrap_up !== 1'b1) begin
            n_fail++;
            $display("FAIL async_strobe_pre: wu=%b need 1", wrap_up);
        end else n_pass++;
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({count, wrap_up, wrap_dn} !== {8'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_strobe: count=%0d wu=%b wd=%b, need 0 0 0", count, wrap_up, wrap_dn);
        end else n_pass++;
        tick();
        tick();
        n_checks++;
        if ({count, wrap_up} !== {8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_hold: count=%0d wu=%b, need 0 0", count, wrap_up);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_checks++;
        if (count !== 8'd1) begin
            n_fail++;
            $display("FAIL async_release: count=%0d need 1", count);
        end else n_pass++;
        en = 1'b0;
    endtask

    task automatic test_dir_flip();
        logic [7:0] exp_c [7] = '{8'd6, 8'd5, 8'd6, 8'd5, 8'd5, 8'd5, 8'd5};
        load = 1'b1; load_val = 8'd5;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i >= 4) en = 1'b0;
            tick();
            n_checks++;
            if ({count, wrap_up, wrap_dn} !== {exp_c[i], 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL dir_flip[%0d]: count=%0d wu=%b wd=%b, need %0d 0 0",
                         i, count, wrap_up, wrap_dn, exp_c[i]);
            end else n_pass++;
            up = ~up;
        end
    endtask

    task automatic test_pow2_wrap();
        p_load = 1'b1; p_load_val = 8'd250;
        tick();
        p_load = 1'b0; p_en = 1'b1; p_up = 1'b1;
        repeat (5) tick();
        n_checks++;
        if ({p_count, p_at_max, p_wrap_up} !== {8'd255, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL pow2_top: count=%0d max=%b wu=%b, need 255 1 0", p_count, p_at_max, p_wrap_up);
        end else n_pass++;
        tick();
        p_en = 1'b0;
        n_checks++;
`ifdef MOD_COUNTER_SATURATE_EN
        if ({p_count, p_wrap_up, p_wrap_dn} !== {8'd255, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL pow2_wrap: count=%0d wu=%b wd=%b, need 255 1 0", p_count, p_wrap_up, p_wrap_dn);
        end else n_pass++;
`else
        if ({p_count, p_wrap_up, p_wrap_dn, p_at_min} !== {8'd0, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL pow2_wrap: count=%0d wu=%b wd=%b min=%b, need 0 1 0 1",
                     p_count, p_wrap_up, p_wrap_dn, p_at_min);
        end else n_pass++;
`endif
        tick();
        n_checks++;
        if (p_wrap_up !== 1'b0) begin
            n_fail++;
            $display("FAIL pow2_pulse: wu=%b need 0", p_wrap_up);
        end else n_pass++;
    endtask

    initial begin
        clr = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; up = 1'b1;
        p_clr = 1'b0; p_load = 1'b0; p_load_val = '0; p_en = 1'b0; p_up = 1'b1;
        rst = 1'b1;
        test_reset();
        test_up_count();
        test_down_wrap();
        test_priority_clamp();
        test_back_to_back();
        test_async_reset();
        test_dir_flip();
        test_pow2_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
